// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared definitions for the UART transmit path.
//   - tx_state_t : frame sequencer state encoding
//   - MUX_*      : TX line select encodings driven on mux_sel
//   - cnt_width(): bit counter width for a given frame width (minimum 1)
//   - CNT_W      : counter width for the default 8-bit frame
package uart_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_t;

   localparam logic [1:0] MUX_START  = 2'b00;   // line driven low
   localparam logic [1:0] MUX_STOP   = 2'b01;   // line driven high (idle/stop)
   localparam logic [1:0] MUX_DATA   = 2'b10;   // serializer output bit
   localparam logic [1:0] MUX_PARITY = 2'b11;   // parity calculator bit

   localparam int DATA_WIDTH_DEF = 8;

   // A 1-bit frame still needs a 1-bit counter, so clamp at 1.
   function automatic int cnt_width(input int dw);
      return (dw > 1) ? $clog2(dw) : 1;
   endfunction

   localparam int CNT_W = cnt_width(DATA_WIDTH_DEF);

endpackage

// File: rtl/uart_bit_counter.sv
// uart_bit_counter: data-bit counter for the frame sequencer.
//   clk   : system clock
//   rst   : synchronous active-high reset (count -> 0)
//   clr   : synchronous clear, takes priority over en
//   en    : advance count by one
//   cnt   : current count
//   tc    : terminal count, high while cnt == data_width-1
module uart_bit_counter
   import uart_tx_pkg::*;
#(
   parameter int data_width = DATA_WIDTH_DEF,
   parameter int cnt_w      = cnt_width(data_width)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [cnt_w-1:0] cnt,
   output logic             tc
);

   localparam logic [cnt_w-1:0] LAST = cnt_w'(data_width - 1);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + cnt_w'(1);
      end
   end

   assign tc = (cnt == LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit frame sequencer. One bit period per clk cycle.
// Steps start, data_width data bits, optional parity and stop bit.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   data_valid : upstream word valid (p_data stable while high)
//   par_en     : parity enable, captured at acceptance
//   busy       : frame in progress (low only in IDLE)
//   ser_load   : serializer load / accept strobe (Mealy)
//   ser_en     : serializer shifts one bit this cycle
//   mux_sel    : TX line select (see MUX_* in uart_tx_pkg)
module uart_tx_ctrl
   import uart_tx_pkg::*;
#(
   parameter int data_width = DATA_WIDTH_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       data_valid,
   input  logic       par_en,
   output logic       busy,
   output logic       ser_load,
   output logic       ser_en,
   output logic [1:0] mux_sel
);

   localparam int CW = cnt_width(data_width);

   tx_state_t       state_q, state_d;
   logic            par_en_q;
   logic [CW-1:0]   bit_cnt;
   logic            bit_tc;
   logic            cnt_clr;
   logic            cnt_en;
   logic            accept;

   // Reset wins over a same-cycle data_valid, so the strobe is gated by rst.
   assign accept = data_valid && (state_q == ST_IDLE) && !rst;

   // Clearing at the last data bit keeps the counter at 0 outside DATA
   // and guarantees it never wraps within a frame.
   assign cnt_en  = (state_q == ST_DATA);
   assign cnt_clr = (state_q != ST_DATA) || bit_tc;

   uart_bit_counter #(
      .data_width (data_width),
      .cnt_w      (CW)
   ) u_bit_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .en  (cnt_en),
      .cnt (bit_cnt),
      .tc  (bit_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         par_en_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            par_en_q <= par_en;
         end
      end
   end

   always_comb begin
      state_d  = ST_IDLE;
      busy     = 1'b0;
      ser_en   = 1'b0;
      mux_sel  = MUX_STOP;
      ser_load = accept;
      case (state_q)
         ST_IDLE: begin
            state_d = accept ? ST_START : ST_IDLE;
         end
         ST_START: begin
            busy    = 1'b1;
            mux_sel = MUX_START;
            state_d = ST_DATA;
         end
         ST_DATA: begin
            busy    = 1'b1;
            ser_en  = 1'b1;
            mux_sel = MUX_DATA;
            if (bit_tc) begin
               state_d = par_en_q ? ST_PARITY : ST_STOP;
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_PARITY: begin
            busy    = 1'b1;
            mux_sel = MUX_PARITY;
            state_d = ST_STOP;
         end
         ST_STOP: begin
            busy    = 1'b1;
            mux_sel = MUX_STOP;
            state_d = ST_IDLE;
         end
         default: begin
            // Unreachable encodings: drive idle outputs and recover.
            state_d  = ST_IDLE;
            ser_load = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: scoreboard bench for uart_tx_ctrl (data_width = 8).
// The driver pushes the hand-derived expected output vector
// {busy, ser_load, ser_en, mux_sel} for every cycle it drives; a monitor
// pops and compares on the falling edge.
module tb_uart_tx_ctrl;
   import uart_tx_pkg::*;

   localparam int DW = 8;

   typedef struct {
      logic [4:0] v;
      string      name;
   } exp_t;

   // {busy, ser_load, ser_en, mux_sel[1:0]}
   localparam logic [4:0] E_IDLE  = {1'b0, 1'b0, 1'b0, MUX_STOP};
   localparam logic [4:0] E_LOAD  = {1'b0, 1'b1, 1'b0, MUX_STOP};
   localparam logic [4:0] E_START = {1'b1, 1'b0, 1'b0, MUX_START};
   localparam logic [4:0] E_DATA  = {1'b1, 1'b0, 1'b1, MUX_DATA};
   localparam logic [4:0] E_PAR   = {1'b1, 1'b0, 1'b0, MUX_PARITY};
   localparam logic [4:0] E_STOP  = {1'b1, 1'b0, 1'b0, MUX_STOP};

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       data_valid = 1'b0;
   logic       par_en = 1'b0;
   logic       busy, ser_load, ser_en;
   logic [1:0] mux_sel;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   uart_tx_ctrl #(.data_width(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .data_valid (data_valid),
      .par_en     (par_en),
      .busy       (busy),
      .ser_load   (ser_load),
      .ser_en     (ser_en),
      .mux_sel    (mux_sel)
   );

   // Monitor: compare one expected vector per cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         logic [4:0] act;
         e   = exp_q.pop_front();
         act = {busy, ser_load, ser_en, mux_sel};
         checks++;
         if (act !== e.v) begin
            failures++;
            $display("FAIL %s t=%0t got busy/load/en/mux=%b required %b",
                     e.name, $time, act, e.v);
         end
      end
   end

   // Drive one cycle of inputs and record what the outputs must be.
   task automatic step(input logic r, input logic dv, input logic pe,
                       input logic [4:0] ev, input string nm);
      rst        = r;
      data_valid = dv;
      par_en     = pe;
      exp_q.push_back('{v: ev, name: nm});
      @(posedge clk);
      #1;
   endtask

   // One frame started from IDLE with a single-cycle data_valid pulse.
   task automatic frame(input logic pe, input string nm);
      step(0, 1, pe, E_LOAD, {nm, "_load"});
      step(0, 0, pe, E_START, {nm, "_start"});
      for (int i = 0; i < DW; i++) step(0, 0, pe, E_DATA, {nm, "_data"});
      if (pe) step(0, 0, pe, E_PAR, {nm, "_par"});
      step(0, 0, pe, E_STOP, {nm, "_stop"});
      step(0, 0, pe, E_IDLE, {nm, "_idle"});
   endtask

   initial begin
      // First edge establishes reset; state unknown before it, so no check.
      @(posedge clk);
      #1;
      // Reset together with data_valid: no acceptance, no strobe.
      step(1, 1, 1, E_IDLE, "rst_dv");
      step(0, 0, 0, E_IDLE, "rst_dv_after");
      for (int i = 0; i < 5; i++) step(0, 0, 0, E_IDLE, "reset_idle");

      frame(1'b1, "par1");
      frame(1'b0, "par0");

      // data_valid held high: two frames separated by one accept/IDLE cycle.
      for (int f = 0; f < 2; f++) begin
         step(0, 1, 1, E_LOAD, "b2b_load");
         step(0, 1, 1, E_START, "b2b_start");
         for (int i = 0; i < DW; i++) step(0, 1, 1, E_DATA, "b2b_data");
         step(0, 1, 1, E_PAR, "b2b_par");
         step(0, 1, 1, E_STOP, "b2b_stop");
      end
      step(0, 0, 1, E_IDLE, "b2b_end");

      // Noise mid-frame: data_valid pulses, par_en toggles; frame w/o parity.
      step(0, 1, 0, E_LOAD, "noise_load");
      step(0, 1, 1, E_START, "noise_start");
      for (int i = 0; i < DW; i++)
         step(0, logic'(i % 2), logic'((i + 1) % 2), E_DATA, "noise_data");
      step(0, 1, 1, E_STOP, "noise_stop");
      step(0, 0, 1, E_IDLE, "noise_idle");

      // Reset during the 4th data bit, then a clean frame.
      step(0, 1, 1, E_LOAD, "mid_load");
      step(0, 0, 1, E_START, "mid_start");
      for (int i = 0; i < 3; i++) step(0, 0, 1, E_DATA, "mid_data");
      step(1, 0, 1, E_DATA, "mid_rst_cycle");
      step(0, 0, 1, E_IDLE, "mid_after_rst");
      step(0, 0, 1, E_IDLE, "mid_after_rst2");
      frame(1'b1, "post_rst");

      // Let the monitor drain, bounded.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         failures++;
         $display("FAIL drain pending=%0d required 0", exp_q.size());
      end
      if (checks < 12) begin
         failures++;
         $display("FAIL check_count got %0d required >=12", checks);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
